nco_clk_ctrl: RTL
=================

Name: nco_clk_ctrl

Overview:
- Run-time controller for the NCO clock-divider path.
- Owns one divider datapath: a half-period timer and a toggle flop.
- Sequences start and stop so that clk_out never produces a runt pulse.
- Accepts new half-period values over a valid/ready handshake and applies them only at a period boundary, so downstream NCO logic always sees whole, clean periods.

Parameters:
- DIV_WIDTH, 16, width of the half-period value and of the internal timer.
- DEFAULT_HALF, 25, half-period in clk_in cycles loaded at reset; must be in 1..2^DIV_WIDTH-1.

Ports:
- clk_in  input  1  sole clock.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk_in.
- run_en  input  1  level: 1 = run the divided clock, 0 = stop it cleanly.
- cfg_valid  input  1  a new half-period value is offered.
- cfg_half  input  DIV_WIDTH  offered half-period value, in clk_in cycles.
- cfg_ready  output  1  controller can accept a value this cycle.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse, high in the same cycle clk_out first reads 1.
- active  output  1  high while in RUN or STOP_WAIT.
- cur_half  output  DIV_WIDTH  half-period value currently in effect.

Behaviour:
- Reset state:
  - state = IDLE, clk_out = 0, tick = 0, active = 0.
  - cur_half = DEFAULT_HALF, timer = 0, pending flag = 0, cfg_ready = 1.
- States: IDLE, RUN, STOP_WAIT.
- IDLE:
  - clk_out held at 0 and timer held at 0.
  - run_en = 1 moves the FSM to RUN on the next edge. Timer starts at 0 in RUN.
- RUN and STOP_WAIT:
  - Timer increments every cycle.
  - When timer == cur_half-1: timer <= 0 and clk_out toggles.
  - Therefore the first rising edge of clk_out occurs cur_half cycles after RUN is entered.
  - tick is registered and high for exactly the one cycle after a 0->1 toggle.
- Stop:
  - run_en = 0 in RUN moves the FSM to STOP_WAIT.
  - STOP_WAIT continues counting until the next 1->0 toggle, then enters IDLE.
  - If clk_out is already 0 in STOP_WAIT, the FSM waits for the next complete high phase to finish; the low phase is not truncated.
  - Net effect: IDLE is entered on the 1->0 toggle, with clk_out = 0.
  - run_en = 1 during STOP_WAIT returns the FSM to RUN without disturbing the timer or clk_out.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - The value goes into the pending register and the pending flag is set; cfg_ready = !pending.
  - A cfg_half of 0 is stored as 1 (clamped).
- Config apply:
  - In IDLE, a pending value is applied on the next edge: cur_half updated, pending cleared.
  - In RUN and STOP_WAIT, a pending value is applied only on the cycle of a 1->0 toggle, together with timer <= 0.
  - The new value therefore governs the complete next period.
- Simultaneous events:
  - An accept in the same cycle as a 1->0 toggle is not applied at that toggle; it is applied at the following one.
  - Stop and apply on the same toggle: both take effect, and IDLE holds the new cur_half.
- Live change of cur_half is never visible mid-period: timer comparisons always use the registered cur_half.
- rst_n asserted mid-operation forces reset values immediately, including clk_out = 0 asynchronously.
- Widths:
  - The timer is DIV_WIDTH bits and never exceeds cur_half-1, so no wrap occurs.
  - Divide ratio is 2*cur_half.

Decomposition:
- Shared package nco_clk_pkg holds:
  - the state enum (IDLE, RUN, STOP_WAIT);
  - the DIV_WIDTH default;
  - the helper function computing a half-period from CLK_IN_FREQ/CLK_OUT_FREQ, so instantiating code can size DEFAULT_HALF.
- One natural sub-module, nco_half_timer: the timer plus toggle flop, with load and clear inputs and a terminal-count output.
- The FSM and handshake stay in the top module.

Test Plan:
- Reset with DEFAULT_HALF=25, then run_en=1:
  - first rising edge of clk_out 25 cycles after RUN is entered;
  - period 50 cycles;
  - tick pulses once every 50 cycles, aligned with the rising edge.
- While running at half=25, offer cfg_half=10 mid-high-phase:
  - cfg_ready drops for one or more cycles;
  - the current period completes at 50 cycles;
  - following periods are 20 cycles;
  - cur_half changes to 10 exactly at the falling toggle.
- run_en=0 in the middle of a low phase:
  - the low phase and the following high phase both complete at full length;
  - clk_out settles at 0 and active falls on the same edge;
  - no runt pulse occurs.
- Offer cfg_half=0 while in IDLE:
  - accepted and stored as 1;
  - after run_en=1, clk_out toggles every cycle (period 2).
- Hold cfg_valid with values 7 then 9 back-to-back while running:
  - 9 is not accepted until 7 has been applied;
  - the periods observed are 14 and then 18.
- Assert rst_n low while clk_out=1 in RUN:
  - clk_out = 0 immediately;
  - state is IDLE and cur_half = DEFAULT_HALF after reset is released.

Source files
------------

// File: rtl/nco_clk_pkg.sv
// Shared types and sizing helpers for the NCO clock-divider controller.
// Imported by nco_half_timer and nco_clk_ctrl; instantiating code may use calc_half().
package nco_clk_pkg;

    localparam int DIV_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_WAIT = 2'd2
    } state_e;

    // Half-period in clk_in cycles for a target output frequency, rounded to nearest, minimum 1.
    function automatic int unsigned calc_half(input longint unsigned clk_in_freq,
                                              input longint unsigned clk_out_freq);
        longint unsigned half;
        if (clk_out_freq == 0) begin
            half = 1;
        end else begin
            half = (clk_in_freq + clk_out_freq) / (2 * clk_out_freq);
        end
        if (half == 0) begin
            half = 1;
        end
        return int'(half[31:0]);
    endfunction

endpackage

// File: rtl/nco_half_timer.sv
// Half-period timer plus toggle flop; o_tc marks the last cycle of a half period.
// Clear forces the idle state (timer 0, clock low); load restarts the current phase from zero.
module nco_half_timer
    import nco_clk_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic                 i_load,
    input  logic [DIV_WIDTH-1:0] i_half,
    output logic                 o_tc,
    output logic                 o_clk_out
);

    logic [DIV_WIDTH-1:0] r_timer;
    logic                 r_clk_out;
    logic [DIV_WIDTH-1:0] w_last;

    assign w_last    = i_half - DIV_WIDTH'(1);
    assign o_tc      = i_en && (r_timer == w_last);
    assign o_clk_out = r_clk_out;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_timer   <= '0;
            r_clk_out <= 1'b0;
        end else if (i_clr) begin
            r_timer   <= '0;
            r_clk_out <= 1'b0;
        end else if (i_en) begin
            if (o_tc) begin
                r_timer   <= '0;
                r_clk_out <= ~r_clk_out;
            end else if (i_load) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/nco_clk_ctrl.sv
// Run/stop sequencer and half-period config handshake around one divider timer.
// New half-periods are held pending and applied only at a falling toggle (or while idle).
module nco_clk_ctrl
    import nco_clk_pkg::*;
#(
    parameter int          DIV_WIDTH    = DIV_WIDTH_DEF,
    parameter int unsigned DEFAULT_HALF = 25
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 run_en,
    input  logic                 cfg_valid,
    input  logic [DIV_WIDTH-1:0] cfg_half,
    output logic                 cfg_ready,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 active,
    output logic [DIV_WIDTH-1:0] cur_half
);

    state_e               r_state;
    logic                 r_pend;
    logic [DIV_WIDTH-1:0] r_pend_half;
    logic [DIV_WIDTH-1:0] r_cur_half;
    logic                 r_tick;

    logic w_run;
    logic w_tc;
    logic w_clk_out;
    logic w_fall;
    logic w_accept;
    logic w_apply;

    assign w_run    = (r_state != ST_IDLE);
    assign w_fall   = w_tc && w_clk_out;
    assign w_accept = cfg_valid && !r_pend;
    // Accept needs an empty slot and apply needs a full one, so they never coincide.
    assign w_apply  = r_pend && (!w_run || w_fall);

    nco_half_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_timer (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .i_en      (w_run),
        .i_clr     (!w_run),
        .i_load    (w_apply),
        .i_half    (r_cur_half),
        .o_tc      (w_tc),
        .o_clk_out (w_clk_out)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pend      <= 1'b0;
            r_pend_half <= '0;
            r_cur_half  <= DIV_WIDTH'(DEFAULT_HALF);
            r_tick      <= 1'b0;
        end else begin
            r_tick <= w_tc && !w_clk_out;
            if (w_apply) begin
                r_cur_half <= r_pend_half;
                r_pend     <= 1'b0;
            end
            if (w_accept) begin
                r_pend      <= 1'b1;
                r_pend_half <= (cfg_half == '0) ? DIV_WIDTH'(1) : cfg_half;
            end
            case (r_state)
                ST_IDLE: begin
                    if (run_en) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!run_en) r_state <= ST_STOP_WAIT;
                end
                ST_STOP_WAIT: begin
                    if (run_en)      r_state <= ST_RUN;
                    else if (w_fall) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready = !r_pend;
    assign clk_out   = w_clk_out;
    assign tick      = r_tick;
    assign active    = w_run;
    assign cur_half  = r_cur_half;

endmodule
